// File: rtl/csa_word_sequencer_if.sv
// Operand/result handshake bundle between the operand source and csa_word_sequencer.
// master = operand source / result consumer, slave = sequencer.
interface csa_word_sequencer_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, op_sub, a, b,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op_sub, a, b,
        output ready, busy, done, result, cout, ovf
    );
endinterface

// File: rtl/csa_word_sequencer.sv
// Wide add/subtract built by issuing one nibble per clock to an external 4-bit
// carry-select adder slice, LSB nibble first, with the carry chained through a flop.
module csa_word_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    csa_word_sequencer_if.slave bus,
    output logic [3:0]          csa_a,
    output logic [3:0]          csa_b,
    output logic                csa_cin,
    input  logic [3:0]          csa_s,
    input  logic                csa_cout
);

    localparam int                 IDX_W    = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic [NIBBLES-1:0][3:0]   a_q, a_d;
    logic [NIBBLES-1:0][3:0]   b_q, b_d;
    logic [NIBBLES-1:0][3:0]   result_q, result_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        csa_a    = 4'h0;
        csa_b    = 4'h0;
        csa_cin  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                    a_d      = bus.a;
                    b_d      = bus.op_sub ? ~bus.b : bus.b;
                    carry_d  = bus.op_sub;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                csa_a          = a_q[idx_q];
                csa_b          = b_q[idx_q];
                csa_cin        = carry_q;
                result_d[idx_q] = csa_s;
                carry_d        = csa_cout;
                idx_d          = idx_q + IDX_ONE;
                if (idx_q == LAST_IDX) begin
                    // Overflow compares against the effective (possibly inverted) B sign.
                    cout_d  = csa_cout;
                    ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                              (csa_s[3] != a_q[NIBBLES-1][3]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: operand registers are reset too; they are only read in RUN, but this keeps them X-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.ready  = (state_q != ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Bench for csa_word_sequencer: behavioural slice, word-level reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_csa_word_sequencer;

    localparam int          NIB   = 4;
    localparam int          W     = 4 * NIB;
    localparam logic [63:0] WMASK = (64'd1 << W) - 64'd1;

    logic       clk;
    logic       rst;
    logic [3:0] csa_a, csa_b, csa_s;
    logic       csa_cin, csa_cout;

    int checks = 0;
    int errors = 0;

    csa_word_sequencer_if #(.NIBBLES(NIB)) bus ();

    csa_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .csa_a    (csa_a),
        .csa_b    (csa_b),
        .csa_cin  (csa_cin),
        .csa_s    (csa_s),
        .csa_cout (csa_cout)
    );

    // External 4-bit adder slice: purely combinational.
    assign {csa_cout, csa_s} = {1'b0, csa_a} + {1'b0, csa_b} + {4'b0, csa_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level reference model ----------------
    function automatic longint to_s(input logic [63:0] x);
        return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    endfunction

    function automatic logic [63:0] exp_res(input logic [63:0] a, input logic [63:0] b, input logic sub);
        return sub ? ((a - b) & WMASK) : ((a + b) & WMASK);
    endfunction

    function automatic logic exp_cout(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] s;
        s = (a + b) >> W;
        return sub ? (a >= b) : s[0];
    endfunction

    function automatic logic exp_ovf(input logic [63:0] a, input logic [63:0] b, input logic sub);
        longint r;
        r = sub ? to_s(a) - to_s(b) : to_s(a) + to_s(b);
        return (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
    endfunction

    // Carry entering nibble i of the word addition a + bx + sub.
    function automatic logic cin_at(input logic [63:0] a, input logic [63:0] bx, input logic sub, input int i);
        logic [63:0] m, t;
        m = (64'd1 << (4 * i)) - 64'd1;
        t = ((a & m) + (bx & m) + {63'd0, sub}) >> (4 * i);
        return t[0];
    endfunction

    logic        m_busy, m_done, m_sub, m_cout, m_ovf;
    int          m_cnt;
    logic [63:0] m_a, m_b, m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_res  <= 64'd0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == NIB - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= exp_res(m_a, m_b, m_sub);
                m_cout <= exp_cout(m_a, m_b, m_sub);
                m_ovf  <= exp_ovf(m_a, m_b, m_sub);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_a    <= 64'(bus.a);
                m_b    <= 64'(bus.b);
                m_sub  <= bus.op_sub;
                m_res  <= 64'd0;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [63:0] bx, er, nmask;
        bx    = m_sub ? (~m_b & WMASK) : m_b;
        nmask = (64'd1 << (4 * m_cnt)) - 64'd1;
        er    = m_busy ? (exp_res(m_a, m_b, m_sub) & nmask) : m_res;
        check("ready",  64'(bus.ready),  64'(!m_busy));
        check("busy",   64'(bus.busy),   64'(m_busy));
        check("done",   64'(bus.done),   64'(m_done));
        check("result", 64'(bus.result), er);
        check("cout",   64'(bus.cout),   64'(m_cout));
        check("ovf",    64'(bus.ovf),    64'(m_ovf));
        if (m_busy) begin
            check("csa_a",   64'(csa_a),   (m_a >> (4 * m_cnt)) & 64'hF);
            check("csa_b",   64'(csa_b),   (bx  >> (4 * m_cnt)) & 64'hF);
            check("csa_cin", 64'(csa_cin), 64'(cin_at(m_a, bx, m_sub, m_cnt)));
        end else begin
            check("csa_a_idle",   64'(csa_a),   64'd0);
            check("csa_b_idle",   64'(csa_b),   64'd0);
            check("csa_cin_idle", 64'(csa_cin), 64'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    logic       cin_log [NIB];
    logic [3:0] b_log   [NIB];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic sub_i, input logic [W-1:0] er, input logic ec, input logic eo);
        int edges;
        bus.a      = a_i;
        bus.b      = b_i;
        bus.op_sub = sub_i;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cin_log[0] = csa_cin;
        b_log[0]   = csa_b;
        edges = 0;
        while (!bus.done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges < NIB) begin
                cin_log[edges] = csa_cin;
                b_log[edges]   = csa_b;
            end
        end
        check({nm, "_latency"}, 64'(edges), 64'(NIB));
        check({nm, "_result"},  64'(bus.result), 64'(er));
        check({nm, "_cout"},    64'(bus.cout), 64'(ec));
        check({nm, "_ovf"},     64'(bus.ovf), 64'(eo));
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready",  64'(bus.ready),  64'd1);
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_csa_a",  64'(csa_a),      64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);

        // 1: plain add, carries into nibbles 1..3
        run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        check("add1_cin0", 64'(cin_log[0]), 64'd0);
        check("add1_cin1", 64'(cin_log[1]), 64'd1);
        check("add1_cin2", 64'(cin_log[2]), 64'd1);
        check("add1_cin3", 64'(cin_log[3]), 64'd1);

        // 2: full ripple, accepted back-to-back in the DONE cycle
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        check("ripple_cin3", 64'(cin_log[3]), 64'd1);
        tick(2);

        // 3: subtraction with and without borrow
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check("sub_neg_cin0", 64'(cin_log[0]), 64'd1);
        check("sub_neg_b0",   64'(b_log[0]),   64'h8);
        tick(1);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        tick(1);

        // 4: signed overflow in both directions
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick(1);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        tick(2);

        // 5: start during RUN is ignored; start held in DONE is accepted
        bus.a = 16'h1111; bus.b = 16'h2222; bus.op_sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        tick(2);
        bus.a = 16'hAAAA; bus.b = 16'h5555; bus.op_sub = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin
            tick(1);
            n++;
        end
        check("hs_first_result", 64'(bus.result), 64'h3333);
        check("hs_first_done",   64'(bus.done),   64'd1);
        bus.a = 16'h4000; bus.b = 16'h1000; bus.op_sub = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin
            tick(1);
            n++;
        end
        check("hs_second_gap",    64'(n),          64'(NIB + 1));
        check("hs_second_result", 64'(bus.result), 64'h3000);
        check("hs_second_cout",   64'(bus.cout),   64'd1);
        tick(2);

        // 6: reset after two nibbles aborts the operation
        bus.a = 16'h1234; bus.b = 16'h1111; bus.op_sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        tick(2);
        check("abort_partial", 64'(bus.result), 64'h0045);
        rst = 1'b1;
        #1;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_ready",  64'(bus.ready),  64'd1);
        check("abort_busy",   64'(bus.busy),   64'd0);
        check("abort_cout",   64'(bus.cout),   64'd0);
        check("abort_csa_a",  64'(csa_a),      64'd0);
        check("abort_cin",    64'(csa_cin),    64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            tick(1);
            check("abort_no_done", 64'(bus.done), 64'd0);
        end
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
